// File: rtl/uart_fifo_if.sv
// Byte-stream and uart_top-facing signal bundle for uart_fifo_ctrl.
// The master modport is the controller; slave is the fabric/UART side.
interface uart_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready;
  logic [7:0]       tx_data;
  logic             tx_wr_en;
  logic             tx_busy;
  logic [7:0]       rx_data;
  logic             rx_rdy;
  logic             rx_rdy_clr;
  logic [LVL_W-1:0] tx_level;
  logic [LVL_W-1:0] rx_level;
  logic             rx_ovf;
  logic             ovf_clr;

  modport master (
    input  s_data, s_valid, m_ready, tx_busy, rx_data, rx_rdy, ovf_clr,
    output s_ready, m_data, m_valid, tx_data, tx_wr_en, rx_rdy_clr,
           tx_level, rx_level, rx_ovf
  );

  modport slave (
    output s_data, s_valid, m_ready, tx_busy, rx_data, rx_rdy, ovf_clr,
    input  s_ready, m_data, m_valid, tx_data, tx_wr_en, rx_rdy_clr,
           tx_level, rx_level, rx_ovf
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Buffers bytes between valid/ready streams and uart_top's byte handshake,
// with a TX FIFO feeding tx_wr_en pulses and an RX FIFO filled via rx_rdy_clr.
module uart_fifo_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  uart_fifo_if.master bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_CLR, RX_WAIT_LOW} rx_state_t;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [AW:0]       tx_wptr, tx_rptr;
  logic [LVL_W-1:0]  tx_cnt;
  logic              tx_full, tx_empty, tx_push, tx_pop;

  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW:0]       rx_wptr, rx_rptr;
  logic [LVL_W-1:0]  rx_cnt;
  logic              rx_full, rx_empty, rx_push, rx_pop;

  tx_state_t         tx_state, tx_nxt;
  logic [1:0]        guard_cnt, guard_nxt;
  logic [DATA_W-1:0] tx_data_q;
  rx_state_t         rx_state, rx_nxt;
  logic              ovf_q, ovf_set;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign tx_cnt   = tx_wptr - tx_rptr;
  assign tx_full  = (tx_cnt == LVL_W'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = bus.s_valid & ~tx_full;

  assign rx_cnt   = rx_wptr - rx_rptr;
  assign rx_full  = (rx_cnt == LVL_W'(DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_push  = (rx_state == RX_CLR);
  assign rx_pop   = ~rx_empty & bus.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= bus.s_data;
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= bus.rx_data;
  end

  // The head is latched and popped on the IDLE->LOAD edge so tx_data is
  // already valid during the cycle tx_wr_en is high.
  always_comb begin
    tx_nxt    = tx_state;
    guard_nxt = guard_cnt;
    tx_pop    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && !bus.tx_busy) begin
          tx_nxt = TX_LOAD;
          tx_pop = 1'b1;
        end
      end
      TX_LOAD: begin
        tx_nxt    = TX_WAIT_BUSY;
        guard_nxt = 2'd0;
      end
      TX_WAIT_BUSY: begin
        if (bus.tx_busy)          tx_nxt    = TX_WAIT_DONE;
        else if (guard_cnt == 2'd2) tx_nxt  = TX_IDLE;
        else                      guard_nxt = guard_cnt + 2'd1;
      end
      TX_WAIT_DONE: begin
        if (!bus.tx_busy) tx_nxt = TX_IDLE;
      end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      guard_cnt <= 2'd0;
      tx_data_q <= '0;
    end else begin
      tx_state  <= tx_nxt;
      guard_cnt <= guard_nxt;
      if (tx_pop) tx_data_q <= tx_mem[tx_rptr[AW-1:0]];
    end
  end

  // WAIT_LOW holds off a new capture until uart_top has dropped rx_rdy.
  always_comb begin
    rx_nxt  = rx_state;
    ovf_set = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (bus.rx_rdy && !rx_full)     rx_nxt  = RX_CLR;
        else if (bus.rx_rdy && rx_full) ovf_set = 1'b1;
      end
      RX_CLR:      rx_nxt = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!bus.rx_rdy) rx_nxt = RX_IDLE;
      default:     rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      ovf_q    <= 1'b0;
    end else begin
      rx_state <= rx_nxt;
      if (ovf_set)          ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign bus.s_ready    = ~tx_full;
  assign bus.tx_level   = tx_cnt;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_wr_en   = (tx_state == TX_LOAD);
  assign bus.m_valid    = ~rx_empty;
  assign bus.m_data     = rx_empty ? '0 : rx_mem[rx_rptr[AW-1:0]];
  assign bus.rx_level   = rx_cnt;
  assign bus.rx_rdy_clr = (rx_state == RX_CLR);
  assign bus.rx_ovf     = ovf_q;
endmodule
